// File: rtl/tx_pkt_if.sv
// Switch / buffer / channel signal bundle for the tx_pkt packet transmitter.
// master: the transmitter side. slave: the environment (switch, buffer, responder).
interface tx_pkt_if #(
    parameter int SIZE         = 8,
    parameter int CHANNEL_BITS = 3,
    parameter int BUFF_BITS    = 3,
    parameter int LEN_BITS     = 4
);
    logic                    sw_req;
    logic [CHANNEL_BITS-1:0] sw_chnl;
    logic [BUFF_BITS-1:0]    sw_base;
    logic [LEN_BITS-1:0]     sw_len;
    logic                    sw_gnt;
    logic                    sw_done;
    logic [CHANNEL_BITS-1:0] cur_chnl;
    logic [BUFF_BITS-1:0]    buf_addr;
    logic [SIZE-1:0]         buf_data;
    logic                    ch_req;
    logic [SIZE-1:0]         ch_flit;
    logic                    ch_ack;

    modport master (
        input  sw_req, sw_chnl, sw_base, sw_len, buf_data, ch_ack,
        output sw_gnt, sw_done, cur_chnl, buf_addr, ch_req, ch_flit
    );

    modport slave (
        output sw_req, sw_chnl, sw_base, sw_len, buf_data, ch_ack,
        input  sw_gnt, sw_done, cur_chnl, buf_addr, ch_req, ch_flit
    );
endinterface

// File: rtl/tx_pkt.sv
// Packet transmitter: on a switch request, streams sw_len flits read from a
// buffer starting at sw_base onto a two-phase req/ack channel.
module tx_pkt #(
    parameter int SIZE         = 8,
    parameter int CHANNEL_BITS = 3,
    parameter int BUFF_BITS    = 3,
    parameter int LEN_BITS     = 4
) (
    input logic     clk,
    input logic     reset,
    tx_pkt_if.master bus
);

    localparam int SUM_W = (BUFF_BITS > LEN_BITS) ? BUFF_BITS : LEN_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_armed;
    logic                    r_ack_old;
    logic                    r_pend;
    logic                    r_ch_req;
    logic [SIZE-1:0]         r_ch_flit;
    logic                    r_sw_gnt;
    logic                    r_sw_done;
    logic [CHANNEL_BITS-1:0] r_cur_chnl;
    logic [BUFF_BITS-1:0]    r_base;
    logic [LEN_BITS-1:0]     r_len;
    logic [LEN_BITS-1:0]     r_cnt;

    logic                    w_ack;
    logic                    w_accept;
    logic                    w_zero;
    logic                    w_load;
    logic                    w_step;
    logic                    w_finish;
    logic                    w_last;
    logic [LEN_BITS:0]       w_cnt_inc;
    logic [BUFF_BITS-1:0]    w_buf_addr;

    // Buffer address wraps modulo 2^BUFF_BITS regardless of the counter width.
    function automatic logic [BUFF_BITS-1:0] addr_sum(
        input logic [BUFF_BITS-1:0] base,
        input logic [LEN_BITS-1:0]  cnt
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(base) + SUM_W'(cnt);
        return s[BUFF_BITS-1:0];
    endfunction

    assign w_ack      = bus.ch_ack ^ r_ack_old;
    assign w_cnt_inc  = {1'b0, r_cnt} + {{LEN_BITS{1'b0}}, 1'b1};
    assign w_last     = (w_cnt_inc == {1'b0, r_len});
    assign w_buf_addr = (r_state == ST_IDLE) ? bus.sw_base : addr_sum(r_base, r_cnt);

    assign bus.buf_addr = w_buf_addr;
    assign bus.ch_req   = r_ch_req;
    assign bus.ch_flit  = r_ch_flit;
    assign bus.sw_gnt   = r_sw_gnt;
    assign bus.sw_done  = r_sw_done;
    assign bus.cur_chnl = r_cur_chnl;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; DONE is held until the request drops so a held request is not resent.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)    w_state_nxt = ST_SEND;
                else if (w_zero) w_state_nxt = ST_DONE;
            end
            ST_SEND: begin
                if (w_finish) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.sw_req) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Action strobes per state; acks outside SEND, or while a flit load is pending, are dropped.
    always_comb begin
        w_accept = 1'b0;
        w_zero   = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && bus.sw_req) begin
                    if (bus.sw_len != '0) w_accept = 1'b1;
                    else                  w_zero   = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_pend) begin
                    w_load = 1'b1;
                end else if (w_ack) begin
                    if (w_last) w_finish = 1'b1;
                    else        w_step   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Ack edge detector history, plus an arm flag that keeps the first post-reset cycle inert.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack_old <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_ack_old <= bus.ch_ack;
            r_armed   <= 1'b1;
        end
    end

    // Packet descriptor capture on accept; later switch-side changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base     <= '0;
            r_len      <= '0;
            r_cur_chnl <= '0;
        end else if (w_accept) begin
            r_base     <= bus.sw_base;
            r_len      <= bus.sw_len;
            r_cur_chnl <= bus.sw_chnl;
        end
    end

    // Flit counter; the pending flag gives buf_addr one cycle to settle on the new address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt  <= '0;
                r_pend <= 1'b0;
            end else if (w_step) begin
                r_cnt  <= w_cnt_inc[LEN_BITS-1:0];
                r_pend <= 1'b1;
            end else if (w_load) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Channel side: each loaded flit is announced by one ch_req toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ch_req  <= 1'b0;
            r_ch_flit <= '0;
        end else if (w_accept || w_load) begin
            r_ch_req  <= ~r_ch_req;
            r_ch_flit <= bus.buf_data;
        end
    end

    // Switch side: grant spans the transfer, done pulses once when the packet completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_gnt  <= 1'b0;
            r_sw_done <= 1'b0;
        end else begin
            if (w_accept)      r_sw_gnt <= 1'b1;
            else if (w_finish) r_sw_gnt <= 1'b0;
            r_sw_done <= w_zero | w_finish;
        end
    end

endmodule

// File: tb/tb_tx_pkt.sv
// Self-checking bench for tx_pkt: buffer model, two-phase responder and a
// negedge monitor that records every flit announced on the channel.
module tb_tx_pkt;
    localparam int SIZE = 8;
    localparam int CB   = 3;
    localparam int BB   = 3;
    localparam int LB   = 4;
    localparam int NBUF = 1 << BB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tx_pkt_if #(.SIZE(SIZE), .CHANNEL_BITS(CB), .BUFF_BITS(BB), .LEN_BITS(LB)) bus ();

    tx_pkt #(.SIZE(SIZE), .CHANNEL_BITS(CB), .BUFF_BITS(BB), .LEN_BITS(LB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [SIZE-1:0] mem [NBUF];
    assign bus.buf_data = mem[bus.buf_addr];

    int checks = 0;
    int errors = 0;

    // monitor state
    int cyc = 0, tog_cnt = 0, done_cnt = 0, gnt_cnt = 0, first_cyc = 0, done_cyc = 0;
    logic prev_req = 1'b0;
    logic [SIZE-1:0] flit_q [$];
    logic [BB-1:0]   addr_q [$];

    // responder state
    bit   resp_en = 1'b1;
    int   resp_dly = 1;
    int   resp_gen = 0;
    logic seen_req = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                prev_req = bus.ch_req;
            end else begin
                if (bus.ch_req !== prev_req) begin
                    tog_cnt++;
                    if (tog_cnt == 1) first_cyc = cyc;
                    flit_q.push_back(bus.ch_flit);
                    addr_q.push_back(bus.buf_addr);
                    prev_req = bus.ch_req;
                end
                if (bus.sw_done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (bus.sw_gnt === 1'b1) gnt_cnt++;
            end
        end
    end

    initial begin
        int my_gen;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && reset && bus.ch_req !== seen_req) begin
                seen_req = bus.ch_req;
                my_gen = resp_gen;
                repeat (resp_dly) @(posedge clk);
                #1;
                while (!resp_en && my_gen == resp_gen) begin
                    @(posedge clk);
                    #1;
                end
                if (my_gen == resp_gen) bus.ch_ack = ~bus.ch_ack;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_mon();
        tog_cnt = 0; done_cnt = 0; gnt_cnt = 0; first_cyc = 0; done_cyc = 0;
        flit_q.delete();
        addr_q.delete();
    endtask

    task automatic fill_random();
        for (int i = 0; i < NBUF; i++) mem[i] = SIZE'($urandom);
    endtask

    // Presents one request and waits (bounded) for sw_done, then drops sw_req.
    task automatic run_packet(input int chnl, input int base, input int len, input int dly,
                              input bit scramble, output bit ok, output logic start_req);
        @(posedge clk);
        #1;
        clr_mon();
        start_req    = bus.ch_req;
        resp_dly     = dly;
        bus.sw_chnl  = CB'(chnl);
        bus.sw_base  = BB'(base);
        bus.sw_len   = LB'(len);
        bus.sw_req   = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (scramble && tog_cnt > 0) begin
                bus.sw_chnl = CB'($urandom);
                bus.sw_base = BB'($urandom);
                bus.sw_len  = LB'($urandom);
            end
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.sw_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.sw_base = 3'd5;
        #1;
        checks++; if (bus.ch_req !== 1'b0)  begin errors++; $display("FAIL rst_ch_req got %b want 0", bus.ch_req); end
        checks++; if (bus.ch_flit !== '0)   begin errors++; $display("FAIL rst_ch_flit got %h want 0", bus.ch_flit); end
        checks++; if (bus.sw_gnt !== 1'b0)  begin errors++; $display("FAIL rst_sw_gnt got %b want 0", bus.sw_gnt); end
        checks++; if (bus.sw_done !== 1'b0) begin errors++; $display("FAIL rst_sw_done got %b want 0", bus.sw_done); end
        checks++; if (bus.cur_chnl !== '0)  begin errors++; $display("FAIL rst_cur_chnl got %0d want 0", bus.cur_chnl); end
        checks++; if (bus.buf_addr !== 3'd5) begin errors++; $display("FAIL rst_buf_addr got %0d want 5", bus.buf_addr); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok; logic sr;
        for (int i = 0; i < NBUF; i++) mem[i] = SIZE'(i + 10);
        run_packet(3, 0, 8, 1, 1'b0, ok, sr);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout done not seen"); end
        checks++; if (tog_cnt != 8) begin errors++; $display("FAIL basic_toggles got %0d want 8", tog_cnt); end
        for (int i = 0; i < 8 && i < flit_q.size(); i++) begin
            checks++;
            if (flit_q[i] !== SIZE'(i + 10)) begin
                errors++; $display("FAIL basic_flit[%0d] got %0d want %0d", i, flit_q[i], i + 10);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt); end
        checks++; if (gnt_cnt != done_cyc - first_cyc) begin
            errors++; $display("FAIL basic_gnt_len got %0d want %0d", gnt_cnt, done_cyc - first_cyc); end
        checks++; if (bus.cur_chnl !== 3'd3) begin errors++; $display("FAIL basic_cur_chnl got %0d want 3", bus.cur_chnl); end
        checks++; if (bus.ch_req !== sr) begin errors++; $display("FAIL basic_req_parity got %b want %b", bus.ch_req, sr); end
    endtask

    task automatic test_wrap();
        bit ok; logic sr;
        int exp_a;
        fill_random();
        run_packet(1, 6, 4, 2, 1'b0, ok, sr);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout done not seen"); end
        checks++; if (tog_cnt != 4) begin errors++; $display("FAIL wrap_toggles got %0d want 4", tog_cnt); end
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            exp_a = (6 + i) % NBUF;
            checks++;
            if (addr_q[i] !== BB'(exp_a)) begin
                errors++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, addr_q[i], exp_a);
            end
            checks++;
            if (flit_q[i] !== mem[exp_a]) begin
                errors++; $display("FAIL wrap_flit[%0d] got %h want %h", i, flit_q[i], mem[exp_a]);
            end
        end
    endtask

    task automatic test_zero_len();
        bit ok; logic sr;
        @(posedge clk);
        #1;
        clr_mon();
        sr = bus.ch_req;
        bus.sw_len = '0; bus.sw_base = 3'd2; bus.sw_req = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (tog_cnt != 0)  begin errors++; $display("FAIL zero_toggles got %0d want 0", tog_cnt); end
        checks++; if (gnt_cnt != 0)  begin errors++; $display("FAIL zero_gnt got %0d want 0", gnt_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done got %0d want 1", done_cnt); end
        checks++; if (bus.ch_req !== sr) begin errors++; $display("FAIL zero_req got %b want %b", bus.ch_req, sr); end
        @(posedge clk);
        #1;
        bus.sw_req = 1'b0;
        fill_random();
        run_packet(4, 3, 2, 1, 1'b0, ok, sr);
        checks++; if (tog_cnt != 2 || !ok) begin errors++; $display("FAIL zero_then_pkt toggles got %0d want 2", tog_cnt); end
    endtask

    task automatic test_stall_spurious();
        bit ok;
        logic sreq;
        logic [SIZE-1:0] sflit;
        fill_random();
        @(posedge clk);
        #1;
        clr_mon();
        resp_dly = 1;
        bus.sw_base = 3'd2; bus.sw_len = 4'd6; bus.sw_chnl = 3'd7; bus.sw_req = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tog_cnt == 3) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL stall_reach third toggle not seen"); end
        resp_en = 1'b0;
        sreq = bus.ch_req;
        sflit = bus.ch_flit;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bus.ch_req !== sreq || bus.ch_flit !== sflit) begin
                errors++; $display("FAIL stall_hold cyc %0d got %b/%h want %b/%h", c, bus.ch_req, bus.ch_flit, sreq, sflit);
            end
        end
        resp_en = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        bus.sw_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (!ok || tog_cnt != 6) begin errors++; $display("FAIL stall_toggles got %0d want 6", tog_cnt); end
        checks++; if (flit_q.size() == 6 && flit_q[5] !== mem[(2 + 5) % NBUF]) begin
            errors++; $display("FAIL stall_last_flit got %h want %h", flit_q[5], mem[(2 + 5) % NBUF]); end
        // spurious ack in IDLE
        @(posedge clk);
        #1;
        clr_mon();
        bus.sw_base = 3'd1;
        bus.ch_ack = ~bus.ch_ack;
        repeat (6) @(negedge clk);
        checks++; if (tog_cnt != 0 || done_cnt != 0 || gnt_cnt != 0) begin
            errors++; $display("FAIL spurious_ack got tog %0d done %0d gnt %0d want 0 0 0", tog_cnt, done_cnt, gnt_cnt); end
        checks++; if (bus.buf_addr !== 3'd1) begin errors++; $display("FAIL spurious_idle_addr got %0d want 1", bus.buf_addr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        fill_random();
        @(posedge clk);
        #1;
        clr_mon();
        resp_dly = 1;
        bus.sw_base = 3'd0; bus.sw_len = 4'd8; bus.sw_chnl = 3'd4; bus.sw_req = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tog_cnt == 3) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rmid_reach third toggle not seen"); end
        resp_en = 1'b0;
        resp_gen++;
        #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.ch_req !== 1'b0 || bus.ch_flit !== '0) begin
            errors++; $display("FAIL rmid_ch got %b/%h want 0/0", bus.ch_req, bus.ch_flit); end
        checks++; if (bus.sw_gnt !== 1'b0 || bus.sw_done !== 1'b0 || bus.cur_chnl !== '0) begin
            errors++; $display("FAIL rmid_sw got gnt %b done %b chnl %0d want 0 0 0", bus.sw_gnt, bus.sw_done, bus.cur_chnl); end
        bus.ch_ack = 1'b0;
        bus.sw_req = 1'b0;
        repeat (2) @(negedge clk);
        seen_req = 1'b0;
        resp_en = 1'b1;
        clr_mon();
        bus.sw_base = 3'd5; bus.sw_len = 4'd2; bus.sw_chnl = 3'd6; bus.sw_req = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.sw_gnt !== 1'b0 || tog_cnt != 0) begin
            errors++; $display("FAIL rmid_first_cycle got gnt %b tog %0d want 0 0", bus.sw_gnt, tog_cnt); end
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        bus.sw_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (!ok || tog_cnt != 2) begin errors++; $display("FAIL rmid_toggles got %0d want 2", tog_cnt); end
        checks++; if (bus.ch_req !== 1'b0) begin errors++; $display("FAIL rmid_final_req got %b want 0", bus.ch_req); end
        checks++; if (flit_q.size() > 0 && flit_q[0] !== mem[5]) begin
            errors++; $display("FAIL rmid_flit0 got %h want %h", flit_q[0], mem[5]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        fill_random();
        @(posedge clk);
        #1;
        clr_mon();
        resp_dly = 1;
        bus.sw_base = 3'd1; bus.sw_len = 4'd3; bus.sw_chnl = 3'd5; bus.sw_req = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        bus.sw_base = 3'd4; bus.sw_len = 4'd2; bus.sw_chnl = 3'd2;
        repeat (10) @(negedge clk);
        checks++; if (!ok || tog_cnt != 3 || done_cnt != 1) begin
            errors++; $display("FAIL b2b_hold got tog %0d done %0d want 3 1", tog_cnt, done_cnt); end
        checks++; if (bus.cur_chnl !== 3'd5) begin errors++; $display("FAIL b2b_chnl1 got %0d want 5", bus.cur_chnl); end
        @(posedge clk);
        #1;
        bus.sw_req = 1'b0;
        @(posedge clk);
        #1;
        clr_mon();
        bus.sw_req = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        bus.sw_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (!ok || tog_cnt != 2) begin errors++; $display("FAIL b2b_second got tog %0d want 2", tog_cnt); end
        checks++; if (bus.cur_chnl !== 3'd2) begin errors++; $display("FAIL b2b_chnl2 got %0d want 2", bus.cur_chnl); end
        checks++; if (flit_q.size() == 2 && (flit_q[0] !== mem[4] || flit_q[1] !== mem[5])) begin
            errors++; $display("FAIL b2b_flits got %h %h want %h %h", flit_q[0], flit_q[1], mem[4], mem[5]); end
    endtask

    task automatic test_random();
        bit ok; logic sr;
        int chnl, base, len, dly, a;
        for (int p = 0; p < 10; p++) begin
            fill_random();
            chnl = $urandom_range(7, 0);
            base = $urandom_range(NBUF - 1, 0);
            len  = $urandom_range(15, 0);
            dly  = $urandom_range(3, 0);
            run_packet(chnl, base, len, dly, 1'b1, ok, sr);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout done not seen", p); end
            checks++; if (tog_cnt != len) begin errors++; $display("FAIL rnd%0d_toggles got %0d want %0d", p, tog_cnt, len); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done got %0d want 1", p, done_cnt); end
            checks++; if (bus.ch_req !== (sr ^ len[0])) begin
                errors++; $display("FAIL rnd%0d_parity got %b want %b", p, bus.ch_req, sr ^ len[0]); end
            for (int i = 0; i < len && i < flit_q.size(); i++) begin
                a = (base + i) % NBUF;
                checks++;
                if (flit_q[i] !== mem[a] || addr_q[i] !== BB'(a)) begin
                    errors++; $display("FAIL rnd%0d_flit[%0d] got %h@%0d want %h@%0d", p, i, flit_q[i], addr_q[i], mem[a], a);
                end
            end
            if (len != 0) begin
                checks++; if (bus.cur_chnl !== CB'(chnl)) begin
                    errors++; $display("FAIL rnd%0d_chnl got %0d want %0d", p, bus.cur_chnl, chnl); end
                checks++; if (gnt_cnt != done_cyc - first_cyc) begin
                    errors++; $display("FAIL rnd%0d_gnt got %0d want %0d", p, gnt_cnt, done_cyc - first_cyc); end
            end else begin
                checks++; if (gnt_cnt != 0) begin errors++; $display("FAIL rnd%0d_gnt0 got %0d want 0", p, gnt_cnt); end
            end
        end
    endtask

    initial begin
        bus.sw_req = 1'b0; bus.sw_chnl = '0; bus.sw_base = '0; bus.sw_len = '0; bus.ch_ack = 1'b0;
        for (int i = 0; i < NBUF; i++) mem[i] = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_stall_spurious();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
